ctrl_pipe_unit: RTL and testbench

//  Pipelined successor to the single-cycle decoder. Decodes the ID-stage instruction into a control

---
 rtl/ctrl_pipe_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall and branch/jump flush. Optional perf counters via CTRL_PERF_CNT_EN.
module ctrl_pipe_unit #(
    parameter int INSTR_W  = 32,
    parameter int ALUCTR_W = 3,
    parameter int RADDR_W  = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  id_instr,
    input  logic                id_valid,
    input  logic                ex_zero,
    input  logic [RADDR_W-1:0]  ex_rt,
    output logic                pc_wr_en,
    output logic                ifid_wr_en,
    output logic                ifid_flush,
    output logic [1:0]          pc_src,
    output logic                ex_alusrc,
    output logic                ex_regdst,
    output logic [ALUCTR_W-1:0] ex_aluctr,
    output logic                ex_extop,
    output logic                ex_branch,
    output logic                mem_memwr,
    output logic                mem_memrd,
    output logic                wb_regwr,
    output logic                wb_memtoreg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
`endif
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_ORI   = 6'b001101,
        OP_ADDIU = 6'b001001,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_BEQ   = 6'b000100,
        OP_J     = 6'b000010
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADDU = 6'b100001,
        FN_SUBU = 6'b100011,
        FN_AND  = 6'b100100,
        FN_OR   = 6'b100101,
        FN_SLT  = 6'b101010
    } func_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef struct packed {
        logic                alusrc;
        logic                regdst;
        logic [ALUCTR_W-1:0] aluctr;
        logic                extop;
        logic                branch;
        logic                memwr;
        logic                memrd;
        logic                regwr;
        logic                memtoreg;
    } idex_ctrl_t;

    typedef struct packed {
        logic memwr;
        logic memrd;
        logic regwr;
        logic memtoreg;
    } exmem_ctrl_t;

    typedef struct packed {
        logic regwr;
        logic memtoreg;
    } memwb_ctrl_t;

    opcode_e            id_op;
    func_e              id_func;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic               unused_imm;

    assign id_op      = opcode_e'(id_instr[INSTR_W-1 -: 6]);
    assign id_func    = func_e'(id_instr[5:0]);
    assign id_rs      = RADDR_W'(id_instr[25:21]);
    assign id_rt      = RADDR_W'(id_instr[20:16]);
    assign unused_imm = ^id_instr[15:6];

    idex_ctrl_t  dec;
    logic        dec_reads_rt;
    logic        dec_jump;

    idex_ctrl_t  idex_d,  idex_q;
    exmem_ctrl_t exmem_d, exmem_q;
    memwb_ctrl_t memwb_d, memwb_q;

    // ---------------------------------------------------------------- decode
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        dec          = '0;
        dec_reads_rt = 1'b0;
        dec_jump     = 1'b0;
        if (id_valid) begin
            case (id_op)
                OP_RTYPE: begin
                    dec.regdst   = 1'b1;
                    dec.regwr    = 1'b1;
                    dec_reads_rt = 1'b1;
                    case (id_func)
                        FN_ADDU: dec.aluctr = ALUCTR_W'(ALU_ADD);
                        FN_SUBU: dec.aluctr = ALUCTR_W'(ALU_SUB);
                        FN_AND:  dec.aluctr = ALUCTR_W'(ALU_AND);
                        FN_OR:   dec.aluctr = ALUCTR_W'(ALU_OR);
                        FN_SLT:  dec.aluctr = ALUCTR_W'(ALU_SLT);
                        default: begin
                            dec.aluctr = ALUCTR_W'(ALU_ADD);
                            dec.regwr  = 1'b0;
                        end
                    endcase
                end
                OP_ORI: begin
                    dec.alusrc = 1'b1;
                    dec.regwr  = 1'b1;
                    dec.aluctr = ALUCTR_W'(ALU_OR);
                end
                OP_ADDIU: begin
                    dec.alusrc = 1'b1;
                    dec.extop  = 1'b1;
                    dec.regwr  = 1'b1;
                    dec.aluctr = ALUCTR_W'(ALU_ADD);
                end
                OP_LW: begin
                    dec.alusrc   = 1'b1;
                    dec.extop    = 1'b1;
                    dec.regwr    = 1'b1;
                    dec.memrd    = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.aluctr   = ALUCTR_W'(ALU_ADD);
                end
                OP_SW: begin
                    dec.alusrc   = 1'b1;
                    dec.extop    = 1'b1;
                    dec.memwr    = 1'b1;
                    dec.aluctr   = ALUCTR_W'(ALU_ADD);
                    dec_reads_rt = 1'b1;
                end
                OP_BEQ: begin
                    dec.branch   = 1'b1;
                    dec.aluctr   = ALUCTR_W'(ALU_SUB);
                    dec_reads_rt = 1'b1;
                end
                OP_J:    dec_jump = 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- hazards
    logic    load_use;
    logic    branch_taken;
    pc_src_e pc_src_sel;

    // The lw in EX is identified by its registered memrd bit; $0 never creates a dependency.
    assign load_use = idex_q.memrd && (ex_rt != '0) && id_valid &&
                      ((ex_rt == id_rs) || (dec_reads_rt && (ex_rt == id_rt)));
    assign branch_taken = idex_q.branch && ex_zero;

    always_comb begin
        pc_wr_en   = 1'b1;
        ifid_wr_en = 1'b1;
        ifid_flush = 1'b0;
        pc_src_sel = PC_SEQ;
        idex_d     = dec;
        // Reset forces the idle hazard state even if ID already holds a j.
        if (!rst) begin
            if (branch_taken) begin
                pc_src_sel = PC_BRANCH;
                ifid_flush = 1'b1;
                idex_d     = '0;
            end else if (load_use) begin
                pc_wr_en   = 1'b0;
                ifid_wr_en = 1'b0;
                idex_d     = '0;
            end else if (dec_jump) begin
                pc_src_sel = PC_JUMP;
                ifid_flush = 1'b1;
                idex_d     = '0;
            end
        end
    end

    assign pc_src = pc_src_sel;

    // ---------------------------------------------------------------- stage registers
    always_comb begin
        exmem_d = '{memwr: idex_q.memwr, memrd: idex_q.memrd,
                    regwr: idex_q.regwr, memtoreg: idex_q.memtoreg};
        memwb_d = '{regwr: exmem_q.regwr, memtoreg: exmem_q.memtoreg};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alusrc   = idex_q.alusrc;
    assign ex_regdst   = idex_q.regdst;
    assign ex_aluctr   = idex_q.aluctr;
    assign ex_extop    = idex_q.extop;
    assign ex_branch   = idex_q.branch;
    assign mem_memwr   = exmem_q.memwr;
    assign mem_memrd   = exmem_q.memrd;
    assign wb_regwr    = memwb_q.regwr;
    assign wb_memtoreg = memwb_q.memtoreg;

`ifdef CTRL_PERF_CNT_EN
    // ---------------------------------------------------------------- perf counters
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_wr_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the packed DUT outputs.
module tb_ctrl_pipe_unit;

    logic        clk;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_zero;
    logic [4:0]  ex_rt;
    logic        pc_wr_en, ifid_wr_en, ifid_flush;
    logic [1:0]  pc_src;
    logic        ex_alusrc, ex_regdst, ex_extop, ex_branch;
    logic [2:0]  ex_aluctr;
    logic        mem_memwr, mem_memrd, wb_regwr, wb_memtoreg;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    ctrl_pipe_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .ex_zero    (ex_zero),
        .ex_rt      (ex_rt),
        .pc_wr_en   (pc_wr_en),
        .ifid_wr_en (ifid_wr_en),
        .ifid_flush (ifid_flush),
        .pc_src     (pc_src),
        .ex_alusrc  (ex_alusrc),
        .ex_regdst  (ex_regdst),
        .ex_aluctr  (ex_aluctr),
        .ex_extop   (ex_extop),
        .ex_branch  (ex_branch),
        .mem_memwr  (mem_memwr),
        .mem_memrd  (mem_memrd),
        .wb_regwr   (wb_regwr),
        .wb_memtoreg(wb_memtoreg)
`ifdef CTRL_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_wr_en, ifid_wr_en, ifid_flush, pc_src}
    localparam logic [4:0] HZ_RUN    = 5'b11_0_00;
    localparam logic [4:0] HZ_STALL  = 5'b00_0_00;
    localparam logic [4:0] HZ_BRANCH = 5'b11_1_01;
    localparam logic [4:0] HZ_JUMP   = 5'b11_1_10;

    // {alusrc, regdst, aluctr[2:0], extop, branch, memwr, memrd, regwr, memtoreg}
    localparam logic [10:0] C_NOP   = 11'b0_0_000_0_0_0_0_0_0;
    localparam logic [10:0] C_ADDU  = 11'b0_1_000_0_0_0_0_1_0;
    localparam logic [10:0] C_SUBU  = 11'b0_1_001_0_0_0_0_1_0;
    localparam logic [10:0] C_AND   = 11'b0_1_010_0_0_0_0_1_0;
    localparam logic [10:0] C_OR    = 11'b0_1_011_0_0_0_0_1_0;
    localparam logic [10:0] C_SLT   = 11'b0_1_100_0_0_0_0_1_0;
    localparam logic [10:0] C_RBAD  = 11'b0_1_000_0_0_0_0_0_0;
    localparam logic [10:0] C_ORI   = 11'b1_0_011_0_0_0_0_1_0;
    localparam logic [10:0] C_ADDIU = 11'b1_0_000_1_0_0_0_1_0;
    localparam logic [10:0] C_LW    = 11'b1_0_000_1_0_0_1_1_1;
    localparam logic [10:0] C_SW    = 11'b1_0_000_1_0_1_0_0_0;
    localparam logic [10:0] C_BEQ   = 11'b0_0_001_0_1_0_0_0_0;

    localparam logic [15:0] RST_VEC = {HZ_RUN, 11'b0};

    logic [15:0] dut_out;
    assign dut_out = {pc_wr_en, ifid_wr_en, ifid_flush, pc_src, ex_alusrc, ex_regdst,
                      ex_aluctr, ex_extop, ex_branch, mem_memwr, mem_memrd, wb_regwr,
                      wb_memtoreg};

    typedef struct packed {
        logic [31:0] id;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        vec_id  = 0;
    logic [10:0] ent1, ent2, ent3;   // control that entered ID/EX 1, 2, 3 edges ago

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] exp);
        sb_entry_t e;
        e.id  = vec_id;
        e.exp = exp;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // One ID-stage cycle: drive inputs, queue the expected outputs, age the delay line.
    task automatic run(input logic [31:0] instr, input logic valid, input logic zero,
                       input logic [4:0] rt, input logic [4:0] hz, input logic [10:0] ctl);
        @(posedge clk);
        #1;
        id_instr = instr;
        id_valid = valid;
        ex_zero  = zero;
        ex_rt    = rt;
        push({hz, ent1[10:4], ent2[3:2], ent3[1:0]});
        ent3 = ent2;
        ent2 = ent1;
        ent1 = ctl;
    endtask

    // Monitor: compares whenever an expectation is pending.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle%0d", e.id), dut_out, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        id_instr = '0; id_valid = 1'b0; ex_zero = 1'b0; ex_rt = '0;
        ent1 = C_NOP; ent2 = C_NOP; ent3 = C_NOP;
        #1 rst = 1'b1;
        #1 push(RST_VEC);
        @(negedge clk);
        #2 rst = 1'b0;

        // Decode coverage, one instruction per cycle
        run(32'h00221821, 1, 0, 5'd0, HZ_RUN, C_ADDU);
        run(32'h00221823, 1, 0, 5'd2, HZ_RUN, C_SUBU);
        run(32'h00221824, 1, 0, 5'd2, HZ_RUN, C_AND);
        run(32'h00221825, 1, 0, 5'd2, HZ_RUN, C_OR);
        run(32'h0022182A, 1, 0, 5'd2, HZ_RUN, C_SLT);
        run(32'h00221820, 1, 0, 5'd2, HZ_RUN, C_RBAD);
        run(32'h342500FF, 1, 0, 5'd2, HZ_RUN, C_ORI);
        run(32'h24260001, 1, 0, 5'd5, HZ_RUN, C_ADDIU);
        run(32'hAC220004, 1, 0, 5'd6, HZ_RUN, C_SW);
        run(32'hFC000000, 1, 0, 5'd2, HZ_RUN, C_NOP);
        run(32'h00221821, 0, 0, 5'd0, HZ_RUN, C_NOP);
        // lw $2 then addu $3,$2,$4: one stall on rs
        run(32'h8C220000, 1, 0, 5'd0, HZ_RUN,   C_LW);
        run(32'h00441821, 1, 0, 5'd2, HZ_STALL, C_NOP);
        run(32'h00441821, 1, 0, 5'd0, HZ_RUN,   C_ADDU);
        // lw $2 then sw $2: stall on rt
        run(32'h8C220000, 1, 0, 5'd4, HZ_RUN,   C_LW);
        run(32'hAC220004, 1, 0, 5'd2, HZ_STALL, C_NOP);
        run(32'hAC220004, 1, 0, 5'd0, HZ_RUN,   C_SW);
        // lw $5 then ori writing $5: ori does not read rt, no stall
        run(32'h8C250000, 1, 0, 5'd2, HZ_RUN, C_LW);
        run(32'h342500FF, 1, 0, 5'd5, HZ_RUN, C_ORI);
        // lw $0 then reader of $0: exempt
        run(32'h8C200000, 1, 0, 5'd5, HZ_RUN, C_LW);
        run(32'h00001821, 1, 0, 5'd0, HZ_RUN, C_ADDU);
        // beq taken, then beq not taken
        run(32'h10220004, 1, 0, 5'd0, HZ_RUN,    C_BEQ);
        run(32'h00221821, 1, 1, 5'd2, HZ_BRANCH, C_NOP);
        run(32'h00221821, 0, 0, 5'd0, HZ_RUN,    C_NOP);
        run(32'h10220004, 1, 0, 5'd0, HZ_RUN,    C_BEQ);
        run(32'h00221821, 1, 0, 5'd2, HZ_RUN,    C_ADDU);
        // j 0x0800_0010
        run(32'h08000010, 1, 0, 5'd2, HZ_JUMP, C_NOP);
        run(32'h00221821, 0, 0, 5'd0, HZ_RUN,  C_NOP);
        // lw $2 then beq reading $2 via rt: stall, zero flag ignored since EX is not a branch
        run(32'h8C220000, 1, 0, 5'd0, HZ_RUN,   C_LW);
        run(32'h10220004, 1, 1, 5'd2, HZ_STALL, C_NOP);
        run(32'h10220004, 1, 0, 5'd0, HZ_RUN,   C_BEQ);
        run(32'h00221821, 1, 0, 5'd2, HZ_RUN,   C_ADDU);
        run(32'h00000000, 0, 0, 5'd0, HZ_RUN, C_NOP);
        run(32'h00000000, 0, 0, 5'd0, HZ_RUN, C_NOP);
        run(32'h00000000, 0, 0, 5'd0, HZ_RUN, C_NOP);
`ifdef CTRL_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 16'd3);
        check("flush_cnt", flush_cnt, 16'd2);
`endif

        // Asynchronous reset asserted in the middle of a load-use stall
        run(32'h8C220000, 1, 0, 5'd0, HZ_RUN, C_LW);
        @(posedge clk);
        #1;
        id_instr = 32'h00441821; id_valid = 1'b1; ex_zero = 1'b0; ex_rt = 5'd2;
        #1 check("stall_pre_rst", dut_out, {HZ_STALL, C_LW[10:4], 4'b0000});
        rst = 1'b1;
        #1 check("async_rst", dut_out, RST_VEC);
`ifdef CTRL_PERF_CNT_EN
        check("cnt_rst", {stall_cnt[7:0], flush_cnt[7:0]}, 16'h0000);
`endif
        push(RST_VEC);
        @(negedge clk);
        #1;
        id_instr = '0; id_valid = 1'b0; ex_rt = '0;
        ent1 = C_NOP; ent2 = C_NOP; ent3 = C_NOP;
        #1 rst = 1'b0;

        // Recovery: addu flows to wb_regwr three cycles after decode
        run(32'h00221821, 1, 0, 5'd0, HZ_RUN, C_ADDU);
        run(32'h00000000, 0, 0, 5'd2, HZ_RUN, C_NOP);
        run(32'h00000000, 0, 0, 5'd0, HZ_RUN, C_NOP);
        run(32'h00000000, 0, 0, 5'd0, HZ_RUN, C_NOP);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, 0 required", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
